// File: rtl/data_mem_ls.sv
// Byte/half/word data memory for the MIPS MEM stage: little-endian lanes, load extension,
// alignment checking, registered reads and a post-reset hardware clear of every word.
module data_mem_ls #(
   parameter  int WORDS_LOG2 = 8,
   localparam int BA_W       = WORDS_LOG2 + 2
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            clk_enable,
   output logic            busy,
   input  logic            r_en,
   input  logic [BA_W-1:0] r_addr,
   input  logic [1:0]      r_size,
   input  logic            r_unsigned,
   input  logic            w_enable,
   input  logic [BA_W-1:0] w_addr,
   input  logic [1:0]      w_size,
   input  logic [31:0]     w_data,
   output logic [31:0]     o_data,
   output logic            o_valid,
   output logic            o_rerr,
   output logic            o_werr
);

   localparam int DEPTH = 1 << WORDS_LOG2;

   localparam logic [0:0] ST_CLEAR = 1'b0;
   localparam logic [0:0] ST_RUN   = 1'b1;

   logic [31:0]           mem_q [DEPTH];
   logic [0:0]            state_q, state_d;
   logic [WORDS_LOG2-1:0] clr_cnt_q, clr_cnt_d;
   logic [31:0]           data_q, data_d;
   logic                  valid_q, valid_d;
   logic                  rerr_q, rerr_d;
   logic                  werr_q, werr_d;

   logic                  run;
   logic                  ld_acc, st_acc;
   logic                  ld_err, st_err;
   logic [31:0]           rd_word;
   logic [3:0]            st_be;
   logic [31:0]           st_wd;
   logic [WORDS_LOG2-1:0] w_idx;

   function automatic logic addr_err(input logic [1:0] size, input logic [1:0] lo);
      return (size == 2'b11) || (size == 2'b01 && lo[0]) || (size == 2'b10 && lo != 2'b00);
   endfunction

   function automatic logic [31:0] ld_extract(input logic [31:0] word, input logic [1:0] lo,
                                              input logic [1:0] size, input logic uns);
      logic [7:0]  b;
      logic [15:0] h;
      b = word[8*lo +: 8];
      h = word[16*lo[1] +: 16];
      case (size)
         2'b00:   return uns ? {24'd0, b} : {{24{b[7]}}, b};
         2'b01:   return uns ? {16'd0, h} : {{16{h[15]}}, h};
         default: return word;
      endcase
   endfunction

   assign run     = (state_q == ST_RUN);
   assign ld_acc  = run & clk_enable & r_en;
   assign st_acc  = run & clk_enable & w_enable & ~rst;
   assign ld_err  = addr_err(r_size, r_addr[1:0]);
   assign st_err  = addr_err(w_size, w_addr[1:0]);
   assign rd_word = mem_q[r_addr[BA_W-1:2]];
   assign w_idx   = w_addr[BA_W-1:2];

   // Right-aligned store data replicated across lanes; byte enables pick the target lanes.
   always_comb begin
      st_be = 4'b0000;
      st_wd = w_data;
      case (w_size)
         2'b00: begin
            st_be = 4'b0001 << w_addr[1:0];
            st_wd = {4{w_data[7:0]}};
         end
         2'b01: begin
            st_be = w_addr[1] ? 4'b1100 : 4'b0011;
            st_wd = {2{w_data[15:0]}};
         end
         2'b10:   st_be = 4'b1111;
         default: st_be = 4'b0000;
      endcase
   end

   always_comb begin
      state_d   = state_q;
      clr_cnt_d = clr_cnt_q;
      data_d    = data_q;
      valid_d   = valid_q;
      rerr_d    = rerr_q;
      werr_d    = werr_q;
      if (!run) begin
         clr_cnt_d = clr_cnt_q + 1'b1;
         if (&clr_cnt_q) state_d = ST_RUN;
      end else if (clk_enable) begin
         valid_d = ld_acc;
         rerr_d  = ld_acc & ld_err;
         werr_d  = w_enable & st_err;
         if (ld_acc) data_d = ld_err ? 32'd0 : ld_extract(rd_word, r_addr[1:0], r_size, r_unsigned);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_CLEAR;
         clr_cnt_q <= '0;
         data_q    <= '0;
         valid_q   <= 1'b0;
         rerr_q    <= 1'b0;
         werr_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         clr_cnt_q <= clr_cnt_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         rerr_q    <= rerr_d;
         werr_q    <= werr_d;
      end
   end

   // Read data is taken before this edge's store lands, giving read-before-write.
   always_ff @(posedge clk) begin
      if (!run) begin
         mem_q[clr_cnt_q] <= '0;
      end else if (st_acc && !st_err) begin
         for (int k = 0; k < 4; k++) begin
            if (st_be[k]) mem_q[w_idx][8*k +: 8] <= st_wd[8*k +: 8];
         end
      end
   end

   assign busy    = ~run;
   assign o_data  = data_q;
   assign o_valid = valid_q;
   assign o_rerr  = rerr_q;
   assign o_werr  = werr_q;

endmodule

// File: tb/tb_data_mem_ls.sv
// Bench for data_mem_ls: directed scenarios plus random traffic, checked against a
// byte-array memory model with little-endian assembly and extension.
module tb_data_mem_ls;

   localparam int BA_W  = 10;
   localparam int BYTES = 1 << BA_W;

   logic            clk = 1'b0;
   logic            rst;
   logic            clk_enable;
   logic            busy;
   logic            r_en;
   logic [BA_W-1:0] r_addr;
   logic [1:0]      r_size;
   logic            r_unsigned;
   logic            w_enable;
   logic [BA_W-1:0] w_addr;
   logic [1:0]      w_size;
   logic [31:0]     w_data;
   logic [31:0]     o_data;
   logic            o_valid;
   logic            o_rerr;
   logic            o_werr;

   int compared   = 0;
   int mismatched = 0;

   logic [7:0]  mem_b [BYTES];
   logic [31:0] exp_data;
   logic        exp_valid, exp_rerr, exp_werr;

   data_mem_ls #(.WORDS_LOG2(8)) dut (
      .clk(clk), .rst(rst), .clk_enable(clk_enable), .busy(busy),
      .r_en(r_en), .r_addr(r_addr), .r_size(r_size), .r_unsigned(r_unsigned),
      .w_enable(w_enable), .w_addr(w_addr), .w_size(w_size), .w_data(w_data),
      .o_data(o_data), .o_valid(o_valid), .o_rerr(o_rerr), .o_werr(o_werr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic bit model_err(input int a, input int s);
      return (s == 3) || (s == 1 && a % 2 != 0) || (s == 2 && a % 4 != 0);
   endfunction

   function automatic logic [31:0] model_load(input int a, input int s, input bit u);
      int          n;
      logic [31:0] v;
      n = (s == 0) ? 1 : (s == 1) ? 2 : 4;
      v = 32'd0;
      for (int i = 0; i < n; i++) v = v | (32'(mem_b[a + i]) << (8 * i));
      if (n < 4 && !u && v[8 * n - 1]) v = v | ~((32'd1 << (8 * n)) - 32'd1);
      return v;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < BYTES; i++) mem_b[i] = 8'h00;
      exp_data  = 32'd0;
      exp_valid = 1'b0;
      exp_rerr  = 1'b0;
      exp_werr  = 1'b0;
   endtask

   task automatic idle();
      r_en = 1'b0; r_addr = '0; r_size = 2'b00; r_unsigned = 1'b0;
      w_enable = 1'b0; w_addr = '0; w_size = 2'b00; w_data = 32'd0;
   endtask

   // One bus cycle in RUN: drive, update the model, clock, check all outputs.
   task automatic do_op(input bit ren, input int ra, input int rs, input bit ru,
                        input bit wen, input int wa, input int ws, input logic [31:0] wd,
                        input bit ce, input string tag);
      r_en = ren; r_addr = ra[BA_W-1:0]; r_size = rs[1:0]; r_unsigned = ru;
      w_enable = wen; w_addr = wa[BA_W-1:0]; w_size = ws[1:0]; w_data = wd;
      clk_enable = ce;
      if (ce) begin
         exp_valid = ren;
         exp_rerr  = ren && model_err(ra, rs);
         if (ren) exp_data = model_err(ra, rs) ? 32'd0 : model_load(ra, rs, ru);
         exp_werr  = wen && model_err(wa, ws);
         if (wen && !model_err(wa, ws)) begin
            for (int i = 0; i < ((ws == 0) ? 1 : (ws == 1) ? 2 : 4); i++)
               mem_b[wa + i] = wd[8 * i +: 8];
         end
      end
      @(posedge clk); #1;
      chk({tag, ".data"},  o_data, exp_data);
      chk({tag, ".valid"}, 32'(o_valid), 32'(exp_valid));
      chk({tag, ".rerr"},  32'(o_rerr),  32'(exp_rerr));
      chk({tag, ".werr"},  32'(o_werr),  32'(exp_werr));
   endtask

   task automatic wait_clear(output int n, output bit leak);
      n = 0;
      leak = 1'b0;
      while (busy && n < 2000) begin
         @(posedge clk); #1;
         n++;
         if (o_valid || o_werr || o_rerr) leak = 1'b1;
      end
   endtask

   task automatic sweep_words(input string tag);
      for (int i = 0; i < BYTES / 4; i++) do_op(1, 4 * i, 2, 0, 0, 0, 0, 32'd0, 1, tag);
   endtask

   initial begin
      int  n;
      bit  leak;
      int  ra, rs, wa, ws;
      idle();
      clk_enable = 1'b1;
      rst = 1'b1;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      chk("rst.busy",  32'(busy),    32'd1);
      chk("rst.data",  o_data,       32'd0);
      chk("rst.valid", 32'(o_valid), 32'd0);
      chk("rst.rerr",  32'(o_rerr),  32'd0);
      chk("rst.werr",  32'(o_werr),  32'd0);
      rst = 1'b0;
      wait_clear(n, leak);
      chk("clear1.cycles", 32'(n), 32'd256);
      sweep_words("sweep1");

      // Word then byte store, byte loads with both extensions.
      do_op(0, 0, 0, 0, 1, 'h10, 2, 32'h11223344, 1, "st_w10");
      do_op(0, 0, 0, 0, 1, 'h11, 0, 32'h000000AA, 1, "st_b11");
      do_op(1, 'h10, 2, 0, 0, 0, 0, 32'd0, 1, "ld_w10");
      chk("tp.w10", o_data, 32'h1122AA44);
      do_op(1, 'h11, 0, 0, 0, 0, 0, 32'd0, 1, "ld_bs11");
      chk("tp.bs11", o_data, 32'hFFFFFFAA);
      do_op(1, 'h11, 0, 1, 0, 0, 0, 32'd0, 1, "ld_bu11");
      chk("tp.bu11", o_data, 32'h000000AA);

      // Half store in the upper lanes.
      do_op(0, 0, 0, 0, 1, 'h22, 1, 32'h00008001, 1, "st_h22");
      do_op(1, 'h22, 1, 0, 0, 0, 0, 32'd0, 1, "ld_hs22");
      chk("tp.hs22", o_data, 32'hFFFF8001);
      do_op(1, 'h22, 1, 1, 0, 0, 0, 32'd0, 1, "ld_hu22");
      chk("tp.hu22", o_data, 32'h00008001);
      do_op(1, 'h20, 2, 0, 0, 0, 0, 32'd0, 1, "ld_w20");
      chk("tp.w20", o_data, 32'h80010000);

      // Rejected stores, misaligned load, werr single pulse.
      do_op(0, 0, 0, 0, 1, 'h05, 2, 32'hCAFEF00D, 1, "st_w05");
      chk("tp.werr05", 32'(o_werr), 32'd1);
      do_op(0, 0, 0, 0, 1, 'h03, 1, 32'h0000BEEF, 1, "st_h03");
      chk("tp.werr03", 32'(o_werr), 32'd1);
      do_op(1, 'h06, 2, 0, 0, 0, 0, 32'd0, 1, "ld_w06");
      chk("tp.rerr06", 32'(o_rerr), 32'd1);
      chk("tp.data06", o_data, 32'd0);
      do_op(1, 'h04, 2, 0, 0, 0, 0, 32'd0, 1, "ld_w04");
      chk("tp.w04", o_data, 32'd0);
      do_op(1, 'h00, 2, 0, 0, 0, 0, 32'd0, 1, "ld_w00");
      chk("tp.w00", o_data, 32'd0);
      do_op(1, 'h01, 3, 0, 1, 'h08, 3, 32'h1, 1, "illegal_sz");

      // Same-edge load and store, then a stalled load.
      do_op(0, 0, 0, 0, 1, 'h40, 2, 32'h12345678, 1, "st_w40a");
      do_op(1, 'h40, 2, 0, 1, 'h40, 2, 32'hDEADBEEF, 1, "rbw40");
      chk("tp.rbw40", o_data, 32'h12345678);
      do_op(1, 'h40, 2, 0, 0, 0, 0, 32'd0, 1, "ld_w40");
      chk("tp.w40", o_data, 32'hDEADBEEF);
      do_op(1, 'h10, 2, 0, 1, 'h40, 2, 32'h0, 0, "stall");
      chk("tp.stall", o_data, 32'hDEADBEEF);
      do_op(1, 'h40, 2, 0, 0, 0, 0, 32'd0, 1, "ld_w40b");
      do_op(0, 0, 0, 0, 0, 0, 0, 32'd0, 1, "noload");

      // Random traffic, mostly aligned, occasional stalls.
      for (int k = 0; k < 400; k++) begin
         rs = $urandom_range(0, 3);
         ws = $urandom_range(0, 3);
         ra = $urandom_range(0, BYTES - 1);
         wa = $urandom_range(0, BYTES - 1);
         if ($urandom_range(0, 3) != 0 && rs != 3) ra = ra & ~((1 << rs) - 1);
         if ($urandom_range(0, 3) != 0 && ws != 3) wa = wa & ~((1 << ws) - 1);
         if ($urandom_range(0, 1) == 0) wa = (ra & ~3) | (wa & 3);
         do_op($urandom_range(0, 1) == 1, ra, rs, $urandom_range(0, 1) == 1,
               $urandom_range(0, 1) == 1, wa, ws, $urandom, $urandom_range(0, 4) != 0, "rnd");
      end

      // Reset during traffic, with requests held on while clearing.
      rst = 1'b1;
      @(posedge clk); #1;
      model_reset();
      chk("rst2.busy",  32'(busy),    32'd1);
      chk("rst2.valid", 32'(o_valid), 32'd0);
      chk("rst2.data",  o_data,       32'd0);
      rst = 1'b0;
      r_en = 1'b1; r_addr = '0; r_size = 2'b10;
      w_enable = 1'b1; w_addr = '0; w_size = 2'b10; w_data = 32'hFFFFFFFF;
      clk_enable = 1'b1;
      wait_clear(n, leak);
      idle();
      chk("clear2.cycles", 32'(n), 32'd256);
      chk("clear2.drop",   32'(leak), 32'd0);
      sweep_words("sweep2");

      // Reset again 100 cycles into a clear.
      for (int k = 0; k < 64; k++) do_op(0, 0, 0, 0, 1, 16 * k, 2, $urandom, 1, "fill");
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      repeat (100) @(posedge clk);
      #1;
      chk("clear3.mid_busy", 32'(busy), 32'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      model_reset();
      wait_clear(n, leak);
      chk("clear3.cycles", 32'(n), 32'd256);
      sweep_words("sweep3");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
